// File: rtl/weight_fetch_sequencer_if.sv
// Weight BRAM read port plus MXU weight stream, bundled for weight_fetch_sequencer.
// master = sequencer side, slave = BRAM/MXU side.
interface weight_fetch_sequencer_if #(
  parameter int ADDRESS_SIZE_WMEMORY = 32,
  parameter int DATA_WIDTH_WMEMORY   = 64
);
  logic [ADDRESS_SIZE_WMEMORY-1:0] wm_address;
  logic                            wm_ce;
  logic                            wm_we;
  logic                            wm_reset;
  logic [DATA_WIDTH_WMEMORY-1:0]   wm_dout;
  logic [DATA_WIDTH_WMEMORY-1:0]   w_data;
  logic                            w_valid;
  logic                            w_ready;

  modport master (
    output wm_address, wm_ce, wm_we, wm_reset, w_data, w_valid,
    input  wm_dout, w_ready
  );

  modport slave (
    input  wm_address, wm_ce, wm_we, wm_reset, w_data, w_valid,
    output wm_dout, w_ready
  );
endinterface

// File: rtl/weight_fetch_sequencer.sv
// Burst reader from weight BRAM into a 2-entry buffer streaming to the MXU.
// Optional WFS_PERF_COUNTER_EN adds the stall_cycles back-pressure counter.
module weight_fetch_sequencer #(
  parameter int ADDRESS_SIZE_WMEMORY = 32,
  parameter int DATA_WIDTH_WMEMORY   = 64,
  parameter int LEN_WIDTH            = 16
) (
  input  logic                            clk,
  input  logic                            areset,
  input  logic                            start,
  input  logic                            abort,
  input  logic [ADDRESS_SIZE_WMEMORY-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]            num_words,
  output logic                            busy,
  output logic                            done,
  output logic                            start_err,
`ifdef WFS_PERF_COUNTER_EN
  output logic [31:0]                     stall_cycles,
`endif
  weight_fetch_sequencer_if.master        wif
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FINISH} state_e;

  state_e                          state_q, state_d;
  logic [ADDRESS_SIZE_WMEMORY-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]            rem_q, rem_d;
  logic                            inflight_q, inflight_d;
  logic [DATA_WIDTH_WMEMORY-1:0]   buf_q [2];
  logic [DATA_WIDTH_WMEMORY-1:0]   buf_d [2];
  logic                            rd_ptr_q, rd_ptr_d;
  logic                            wr_ptr_q, wr_ptr_d;
  logic [1:0]                      occ_q, occ_d;
  logic                            busy_q, busy_d;
  logic                            done_q, done_d;
  logic                            start_err_q, start_err_d;
`ifdef WFS_PERF_COUNTER_EN
  logic [31:0]                     stall_q, stall_d;
`endif

  logic       pop;
  logic       push;
  logic       issue;
  logic       abort_act;
  logic [1:0] pending;

  assign pop       = (occ_q != 2'd0) && wif.w_ready;
  assign push      = inflight_q && !abort_act;
  assign abort_act = abort && ((state_q == FETCH) || (state_q == DRAIN));
  // Credit counts the slot freed by this cycle's pop, so w_ready=1 sustains one word per cycle.
  assign pending   = occ_q + 2'(inflight_q) - 2'(pop);
  assign issue     = (state_q == FETCH) && !abort && (rem_q != '0) && (pending < 2'd2);

  assign wif.wm_address = addr_q;
  assign wif.wm_ce      = issue;
  assign wif.wm_we      = 1'b0;
  assign wif.wm_reset   = 1'b0;
  assign wif.w_valid    = (occ_q != 2'd0);
  assign wif.w_data     = buf_q[rd_ptr_q];
  assign busy           = busy_q;
  assign done           = done_q;
  assign start_err      = start_err_q;
`ifdef WFS_PERF_COUNTER_EN
  assign stall_cycles   = stall_q;
`endif

  // NOTE: every _d gets its hold value first, so no path through this block can infer a latch.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    inflight_d  = issue;
    buf_d       = buf_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    occ_d       = occ_q + 2'(push) - 2'(pop);
    done_d      = (state_q == FINISH);
    start_err_d = start_err_q | (start && (state_q != IDLE));
`ifdef WFS_PERF_COUNTER_EN
    stall_d     = stall_q;
    if (busy_q && wif.w_valid && !wif.w_ready && (stall_q != '1)) stall_d = stall_q + 32'd1;
`endif

    if (pop) rd_ptr_d = ~rd_ptr_q;
    if (push) begin
      buf_d[wr_ptr_q] = wif.wm_dout;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (issue) begin
      addr_d = addr_q + ADDRESS_SIZE_WMEMORY'(1);
      rem_d  = rem_q - LEN_WIDTH'(1);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          rem_d   = num_words;
          state_d = (num_words == '0) ? FINISH : FETCH;
`ifdef WFS_PERF_COUNTER_EN
          stall_d = '0;
`endif
        end
      end
      FETCH:   if (rem_d == '0) state_d = DRAIN;
      DRAIN:   if (!inflight_q && (occ_q == 2'd0)) state_d = FINISH;
      default: state_d = IDLE;
    endcase

    // Abort drops the buffer and the word still returning from the BRAM.
    if (abort_act) begin
      rem_d      = '0;
      occ_d      = 2'd0;
      inflight_d = 1'b0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
      state_d    = FINISH;
    end

    busy_d = (state_d != IDLE);
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      inflight_q  <= 1'b0;
      // NOTE: the 2-entry buffer is reset so w_data reads 0 out of reset; larger memories would not be.
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      occ_q       <= 2'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      start_err_q <= 1'b0;
`ifdef WFS_PERF_COUNTER_EN
      stall_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      inflight_q  <= inflight_d;
      buf_q       <= buf_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      occ_q       <= occ_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      start_err_q <= start_err_d;
`ifdef WFS_PERF_COUNTER_EN
      stall_q     <= stall_d;
`endif
    end
  end

endmodule

// File: tb/tb_weight_fetch_sequencer.sv
// Scoreboard bench for weight_fetch_sequencer: expected addresses/words are queued at start,
// a negedge monitor pops and compares them as the DUT issues reads and delivers words.
module tb_weight_fetch_sequencer;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          areset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] num_words = '0;
  logic          busy, done, start_err;

  logic          start4 = 1'b0;
  logic          abort4 = 1'b0;
  logic [3:0]    base4 = '0;
  logic [LW-1:0] num4 = '0;
  logic          busy4, done4, err4;
`ifdef WFS_PERF_COUNTER_EN
  logic [31:0]   stall_cycles, stall4;
`endif

  weight_fetch_sequencer_if #(.ADDRESS_SIZE_WMEMORY(AW), .DATA_WIDTH_WMEMORY(DW)) wif ();
  weight_fetch_sequencer_if #(.ADDRESS_SIZE_WMEMORY(4), .DATA_WIDTH_WMEMORY(DW)) wif4 ();

  weight_fetch_sequencer #(.ADDRESS_SIZE_WMEMORY(AW), .DATA_WIDTH_WMEMORY(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .areset(areset), .start(start), .abort(abort),
    .base_addr(base_addr), .num_words(num_words),
    .busy(busy), .done(done), .start_err(start_err),
`ifdef WFS_PERF_COUNTER_EN
    .stall_cycles(stall_cycles),
`endif
    .wif(wif)
  );

  weight_fetch_sequencer #(.ADDRESS_SIZE_WMEMORY(4), .DATA_WIDTH_WMEMORY(DW), .LEN_WIDTH(LW)) dut4 (
    .clk(clk), .areset(areset), .start(start4), .abort(abort4),
    .base_addr(base4), .num_words(num4),
    .busy(busy4), .done(done4), .start_err(err4),
`ifdef WFS_PERF_COUNTER_EN
    .stall_cycles(stall4),
`endif
    .wif(wif4)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a ^ 32'h5A5A_C3C3, ~a};
  endfunction

  function automatic logic [DW-1:0] mem_word4(input logic [3:0] a);
    return {60'h0, a} ^ 64'hF0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // BRAM models: registered read, one cycle after wm_ce.
  always @(posedge clk) if (wif.wm_ce) wif.wm_dout <= mem_word(wif.wm_address);
  always @(posedge clk) if (wif4.wm_ce) wif4.wm_dout <= mem_word4(wif4.wm_address);
  initial wif4.w_ready = 1'b1;

  // Scoreboard state
  logic [AW-1:0] exp_addr[$];
  logic [DW-1:0] exp_data[$];
  logic [3:0]    addr4_log[$];
  logic [DW-1:0] data4_log[$];
  bit aborting = 0;
  int issued = 0, delivered = 0, burst_delivered = 0, ce_cnt = 0;
  int first_ce = -1, last_ce = -1, first_valid = -1;
  int done_count = 0, done_seen = 0, done_cyc = -1, start_cyc = 0;
  int stall_cnt = 0;
  int ready_mode = 0, pat_idx = 0;

  always @(negedge clk) begin
    if (areset) begin
      if (busy && wif.w_valid && !wif.w_ready) stall_cnt++;
      if (wif.w_valid && first_valid < 0) first_valid = cyc;
      if (wif.wm_ce) begin
        issued++;
        ce_cnt++;
        if (first_ce < 0) first_ce = cyc;
        last_ce = cyc;
        check("ce_allowed", !aborting && (exp_addr.size() != 0), 1);
        if (!aborting && exp_addr.size() != 0) check("rd_addr", wif.wm_address, exp_addr.pop_front());
      end
      if (wif.w_valid && wif.w_ready) begin
        delivered++;
        burst_delivered++;
        check("word_expected", exp_data.size() != 0, 1);
        if (exp_data.size() != 0) check("w_data", wif.w_data, exp_data.pop_front());
      end
      // Words issued but not yet handed over must fit the 2-entry buffer after this edge.
      if (wif.wm_ce) check("credit", (issued - delivered) <= 2, 1);
      if (done) begin
        done_count++;
        done_cyc = cyc;
        if (aborting) begin
          exp_addr.delete();
          exp_data.delete();
          aborting = 0;
        end else begin
          check("burst_complete", (exp_data.size() == 0) && (exp_addr.size() == 0), 1);
        end
      end
      if (wif4.wm_ce) addr4_log.push_back(wif4.wm_address);
      if (wif4.w_valid && wif4.w_ready) data4_log.push_back(wif4.w_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       wif.w_ready = 1'b1;
      1: begin wif.w_ready = ((pat_idx % 3) == 0); pat_idx++; end
      2:       wif.w_ready = 1'($urandom_range(0, 1));
      default: wif.w_ready = 1'b0;
    endcase
  endtask

  task automatic run_start(input logic [AW-1:0] b, input logic [LW-1:0] n);
    tick();
    start = 1'b1;
    base_addr = b;
    num_words = n;
    start_cyc = cyc;
    first_ce = -1; last_ce = -1; first_valid = -1;
    issued = 0; delivered = 0; burst_delivered = 0; ce_cnt = 0; stall_cnt = 0;
    done_seen = done_count;
    for (int i = 0; i < int'(n); i++) begin
      exp_addr.push_back(b + AW'(i));
      exp_data.push_back(mem_word(b + AW'(i)));
    end
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_count == done_seen && n < budget) begin
      tick();
      n++;
    end
    check("done_seen", done_count == done_seen + 1, 1);
    done_seen = done_count;
    check("done_pulse_1cyc", done, 0);
    check("idle_after_done", busy, 0);
`ifdef WFS_PERF_COUNTER_EN
    check("stall_cycles", stall_cycles, stall_cnt);
`endif
  endtask

  initial begin
    int n;
    logic [AW-1:0] rb;
    logic [LW-1:0] rn;
    logic [3:0] wrap_exp [4];
    wrap_exp = '{4'hE, 4'hF, 4'h0, 4'h1};
    wif.w_ready = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_start_err", start_err, 0);
    check("rst_wm_ce", wif.wm_ce, 0);
    check("rst_wm_address", wif.wm_address, 0);
    check("rst_wm_we", wif.wm_we, 0);
    check("rst_wm_reset", wif.wm_reset, 0);
    check("rst_w_valid", wif.w_valid, 0);
    check("rst_w_data", wif.w_data, 0);
    areset = 1'b1;
    tick();

    // Basic burst, w_ready held high
    ready_mode = 0;
    run_start(32'h10, 16'd4);
    check("basic_busy", busy, 1);
    wait_done(40);
    check("basic_first_ce", first_ce, start_cyc + 1);
    check("basic_last_ce", last_ce, start_cyc + 4);
    check("basic_ce_cnt", ce_cnt, 4);
    check("basic_first_valid", first_valid, start_cyc + 3);
    check("basic_len", burst_delivered, 4);

    // Back-pressure 1,0,0 pattern
    ready_mode = 1;
    pat_idx = 0;
    run_start(32'h40, 16'd8);
    wait_done(200);
    check("bp_len", burst_delivered, 8);

    // Zero length
    ready_mode = 0;
    run_start(32'h80, 16'd0);
    wait_done(20);
    check("zero_done_cyc", done_cyc, start_cyc + 2);
    check("zero_no_ce", ce_cnt, 0);
    check("zero_no_valid", first_valid, -1);

    // Address wrap on a 4-bit address instance
    tick();
    start4 = 1'b1; base4 = 4'hE; num4 = 16'd4;
    tick();
    start4 = 1'b0;
    n = 0;
    while (!done4 && n < 40) begin tick(); n++; end
    check("wrap_done", done4, 1);
    check("wrap_addr_cnt", addr4_log.size(), 4);
    check("wrap_data_cnt", data4_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < addr4_log.size()) check("wrap_addr", addr4_log[i], wrap_exp[i]);
      if (i < data4_log.size()) check("wrap_data", data4_log[i], mem_word4(wrap_exp[i]));
    end

    // Illegal start during busy, then abort after 2 transfers of a 6-word burst
    ready_mode = 0;
    check("start_err_clear", start_err, 0);
    run_start(32'h200, 16'd6);
    start = 1'b1; base_addr = 32'h900; num_words = 16'd3;
    tick();
    start = 1'b0;
    check("start_err_set", start_err, 1);
    n = 0;
    while (burst_delivered < 2 && n < 40) begin tick(); n++; end
    check("abort_reached_2", burst_delivered, 2);
    aborting = 1;
    abort = 1'b1;
    wif.w_ready = 1'b0;
    tick();
    abort = 1'b0;
    check("abort_valid_low", wif.w_valid, 0);
    wait_done(20);
    check("abort_len", burst_delivered, 2);
    check("start_err_sticky", start_err, 1);

    // Randomized bursts with random back-pressure
    ready_mode = 2;
    for (int k = 0; k < 8; k++) begin
      rb = $urandom;
      rn = LW'($urandom_range(0, 10));
      run_start(rb, rn);
      wait_done(300);
      check("rand_len", burst_delivered, rn);
    end

`ifdef WFS_PERF_COUNTER_EN
    // Exactly three stalled cycles
    ready_mode = 3;
    run_start(32'h500, 16'd1);
    n = 0;
    while (stall_cnt < 3 && n < 50) begin tick(); n++; end
    ready_mode = 0;
    wif.w_ready = 1'b1;
    wait_done(50);
    check("stall_three", stall_cycles, 3);
`endif

    // Async reset mid-burst with a full buffer
    ready_mode = 3;
    run_start(32'h300, 16'd8);
    repeat (5) tick();
    check("full_outstanding", issued - delivered, 2);
    check("full_valid", wif.w_valid, 1);
    #2;
    areset = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_start_err", start_err, 0);
    check("arst_wm_ce", wif.wm_ce, 0);
    check("arst_wm_address", wif.wm_address, 0);
    check("arst_w_valid", wif.w_valid, 0);
    check("arst_w_data", wif.w_data, 0);
`ifdef WFS_PERF_COUNTER_EN
    check("arst_stall", stall_cycles, 0);
`endif
    exp_addr.delete();
    exp_data.delete();
    aborting = 0;
    tick();
    tick();
    areset = 1'b1;
    ready_mode = 0;
    run_start(32'h400, 16'd3);
    wait_done(40);
    check("post_rst_len", burst_delivered, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
